// File: rtl/atomic_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : atomic_counter_bank
// Brief    : NUM_CH event counters read as BUS_W-wide words; the first
//            (atomic) word snapshots the whole counter. Optional saturating
//            counters when ATOMIC_CNT_SAT_EN is defined.
// Revision : 1.0
// ============================================================================
module atomic_counter_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int BUS_W  = 32,
    localparam int N_WORDS = (BUS_W > 0) ? CNT_W / BUS_W : 1,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] trig_i,
    input  logic              req_i,
    input  logic              atomic_i,
    input  logic [SEL_W-1:0]  ch_sel_i,
    output logic              ack_o,
    output logic [BUS_W-1:0]  count_o,
    output logic              err_o
);

    generate
        if (NUM_CH < 1 || BUS_W < 1 || CNT_W < BUS_W || (CNT_W % BUS_W) != 0) begin : g_bad_cfg
            $error("atomic_counter_bank: illegal NUM_CH/CNT_W/BUS_W combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CNT_W-1:0] r_snap;
    logic [IDX_W-1:0] r_idx;
    state_t           r_state;
    logic             r_ack;
    logic [BUS_W-1:0] r_count;
    logic             r_err;

    logic [CNT_W-1:0] w_sel_cnt;
    logic             w_sel_ok;
    logic [BUS_W-1:0] w_snap_words [N_WORDS];
    logic [BUS_W-1:0] w_snap_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (trig_i[c]) begin
`ifdef ATOMIC_CNT_SAT_EN
                    if (r_cnt[c] != '1) r_cnt[c] <= r_cnt[c] + 1'b1;
`else
                    r_cnt[c] <= r_cnt[c] + 1'b1;
`endif
                end
            end
        end
    end

    // An out-of-range channel selects nothing, so the snapshot becomes zero.
    always_comb begin
        w_sel_cnt = '0;
        w_sel_ok  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(ch_sel_i) == c) begin
                w_sel_cnt = r_cnt[c];
                w_sel_ok  = 1'b1;
            end
        end
    end

    generate
        for (genvar w = 0; w < N_WORDS; w++) begin : g_word
            assign w_snap_words[w] = r_snap[w*BUS_W +: BUS_W];
        end
    endgenerate

    always_comb begin
        w_snap_word = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (32'(r_idx) == w) w_snap_word = w_snap_words[w];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
            r_ack   <= 1'b0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= req_i;
            if (req_i) begin
                if (atomic_i) begin
                    r_snap  <= w_sel_cnt;
                    r_count <= w_sel_cnt[BUS_W-1:0];
                    r_err   <= ~w_sel_ok;
                    if (N_WORDS > 1) begin
                        r_idx   <= IDX_W'(1);
                        r_state <= ST_SEQ;
                    end else begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end
                end else if (r_state == ST_SEQ) begin
                    r_count <= w_snap_word;
                    r_err   <= 1'b0;
                    if (r_idx == IDX_W'(N_WORDS - 1)) begin
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end else begin
                    r_count <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign ack_o   = r_ack;
    assign count_o = r_count;
    assign err_o   = r_err;

endmodule
`default_nettype wire
